// File: rtl/audio_sfx_arbiter_if.sv
// Bundles the request inputs and the sample/status outputs of audio_sfx_arbiter.
// The master side belongs to the game logic; the slave side belongs to the arbiter.
interface audio_sfx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned GidW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*16-1:0] half_period;
  logic [NUM_REQ*16-1:0] duration;
  logic                  mute;
  logic                  busy;
  logic [GidW-1:0]       grant_id;
  logic [NUM_REQ-1:0]    done;
  logic signed [15:0]    dacdata_left;
  logic signed [15:0]    dacdata_right;

  modport master (
    output req, half_period, duration, mute,
    input  busy, grant_id, done, dacdata_left, dacdata_right
  );

  modport slave (
    input  req, half_period, duration, mute,
    output busy, grant_id, done, dacdata_left, dacdata_right
  );
endinterface

// File: rtl/audio_sfx_arbiter.sv
// Fixed-priority square-wave sound-effect scheduler sharing one DAC path.
// Lower requester index wins; samples advance once per synchronized DAC frame.
module audio_sfx_arbiter #(
  parameter int unsigned        NUM_REQ   = 4,
  parameter logic signed [15:0] AMPLITUDE = 16'sh2000
) (
  input  logic                CLOCK31_5,
  input  logic                resetN,
  input  logic                AUD_DACLRCK,
  audio_sfx_arbiter_if.slave  bus
);

  localparam int unsigned GidW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e             state_q, state_d;
  logic               lrck_meta_q, lrck_sync_q, lrck_prev_q, tick_q;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [15:0]        hp_q [NUM_REQ];
  logic [15:0]        hp_d [NUM_REQ];
  logic [15:0]        dur_q [NUM_REQ];
  logic [15:0]        dur_d [NUM_REQ];
  logic [GidW-1:0]    grant_q, grant_d;
  logic [15:0]        rem_q, rem_d;
  logic [15:0]        phase_q, phase_d;
  logic               pol_q, pol_d;
  logic signed [15:0] sample_q, sample_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic [NUM_REQ-1:0] pend_clr;
  logic [NUM_REQ-1:0] preempt_v;
  logic [GidW-1:0]    cur;
  logic [15:0]        cur_rem, cur_phase, cur_hp;
  logic               cur_pol;

  function automatic logic [GidW-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
    logic [GidW-1:0] idx;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = GidW'(i);
    end
    return idx;
  endfunction

  // Frame clock crosses domains: two sync stages, then a registered rising-edge pulse.
  always_ff @(posedge CLOCK31_5 or negedge resetN) begin
    if (!resetN) begin
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      lrck_meta_q <= AUD_DACLRCK;
      lrck_sync_q <= lrck_meta_q;
      lrck_prev_q <= lrck_sync_q;
      tick_q      <= lrck_sync_q & ~lrck_prev_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      preempt_v[i] = pending_q[i] && (i < int'(grant_q));
    end
  end

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    dur_d     = dur_q;
    grant_d   = grant_q;
    rem_d     = rem_q;
    phase_d   = phase_q;
    pol_d     = pol_q;
    sample_d  = sample_q;
    done_d    = '0;
    pend_clr  = '0;
    cur       = grant_q;
    cur_rem   = rem_q;
    cur_phase = phase_q;
    cur_pol   = pol_q;
    cur_hp    = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i]) begin
        hp_d[i]  = bus.half_period[16*i +: 16];
        dur_d[i] = bus.duration[16*i +: 16];
      end
    end

    unique case (state_q)
      StIdle: begin
        sample_d = '0;
        if (|pending_q) begin
          cur           = lowest_idx(pending_q);
          grant_d       = cur;
          pend_clr[cur] = 1'b1;
          rem_d         = dur_q[cur];
          phase_d       = '0;
          pol_d         = 1'b1;
          state_d       = StPlay;
        end
      end
      StPlay: begin
        if (tick_q) begin
          // A higher-priority arrival replaces the current tone on this very tick.
          if (|preempt_v) begin
            cur           = lowest_idx(preempt_v);
            cur_rem       = dur_q[cur];
            cur_phase     = '0;
            cur_pol       = 1'b1;
            pend_clr[cur] = 1'b1;
          end
          grant_d = cur;
          cur_hp  = hp_q[cur];
          phase_d = cur_phase;
          pol_d   = cur_pol;
          rem_d   = cur_rem;
          if (cur_rem == 16'd0) begin
            sample_d    = '0;
            done_d[cur] = 1'b1;
            state_d     = StIdle;
          end else begin
            if (cur_hp == 16'd0 || bus.mute) begin
              sample_d = '0;
            end else begin
              sample_d = cur_pol ? AMPLITUDE : -AMPLITUDE;
            end
            rem_d = cur_rem - 16'd1;
            if (cur_hp != 16'd0) begin
              if (cur_phase == cur_hp - 16'd1) begin
                phase_d = '0;
                pol_d   = ~cur_pol;
              end else begin
                phase_d = cur_phase + 16'd1;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A request in the same cycle as its grant re-queues the source.
    pending_d = (pending_q & ~pend_clr) | bus.req;
  end

  always_ff @(posedge CLOCK31_5 or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StIdle;
      pending_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hp_q[i]  <= '0;
        dur_q[i] <= '0;
      end
      grant_q  <= '0;
      rem_q    <= '0;
      phase_q  <= '0;
      pol_q    <= 1'b1;
      sample_q <= '0;
      done_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hp_q      <= hp_d;
      dur_q     <= dur_d;
      grant_q   <= grant_d;
      rem_q     <= rem_d;
      phase_q   <= phase_d;
      pol_q     <= pol_d;
      sample_q  <= sample_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy          = (state_q == StPlay);
  assign bus.grant_id      = grant_q;
  assign bus.done          = done_q;
  assign bus.dacdata_left  = sample_q;
  assign bus.dacdata_right = sample_q;

endmodule

// File: tb/tb_audio_sfx_arbiter.sv
// Scoreboard bench for audio_sfx_arbiter: a tick-level tone model predicts each frame's
// sample, done pulses, busy and grant; a monitor compares after every DAC frame edge.
module tb_audio_sfx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam logic signed [15:0] AMP = 16'sh2000;

  typedef struct {
    logic signed [15:0] sample;
    logic [3:0]         done;
    logic               busy;
    logic [1:0]         gid;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic lrck;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  audio_sfx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  audio_sfx_arbiter #(.NUM_REQ(NUM_REQ), .AMPLITUDE(AMP)) dut (
    .CLOCK31_5  (clk),
    .resetN     (rst_n),
    .AUD_DACLRCK(lrck),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: tone position is the count of ticks played since grant.
  bit        m_pend [NUM_REQ];
  int        m_hp   [NUM_REQ];
  int        m_dur  [NUM_REQ];
  bit        m_play;
  int        m_gid;
  int        m_k;
  int        m_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_pend[i] = 1'b0; m_hp[i] = 0; m_dur[i] = 0;
    end
    m_play = 1'b0; m_gid = 0; m_k = 0; m_len = 0;
  endtask

  task automatic try_grant();
    bit found;
    found = 1'b0;
    if (!m_play) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && m_pend[i]) begin
          found = 1'b1; m_gid = i; m_pend[i] = 1'b0;
          m_k = 0; m_len = m_dur[i]; m_play = 1'b1;
        end
      end
    end
  endtask

  task automatic model_tick(input bit mute_now, output exp_t e);
    bit found;
    e.sample = '0; e.done = '0;
    found = 1'b0;
    if (m_play) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && m_pend[i] && i < m_gid) begin
          found = 1'b1; m_gid = i; m_pend[i] = 1'b0; m_k = 0; m_len = m_dur[i];
        end
      end
      if (m_k >= m_len) begin
        e.done[m_gid] = 1'b1;
        m_play = 1'b0;
      end else begin
        if (m_hp[m_gid] != 0 && !mute_now)
          e.sample = (((m_k / m_hp[m_gid]) % 2) == 0) ? AMP : -AMP;
        m_k++;
      end
    end
    try_grant();
    e.busy = m_play;
    e.gid  = 2'(m_gid);
  endtask

  // One DAC frame: predict, raise the frame clock, return in the low half of the frame.
  task automatic do_tick(input bit mute_now);
    exp_t e;
    bus.mute = mute_now;
    repeat (4) @(negedge clk);
    model_tick(mute_now, e);
    sb_q.push_back(e);
    lrck = 1'b1;
    repeat (8) @(negedge clk);
    lrck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic issue_req(input logic [3:0] mask, input logic [63:0] hp,
                           input logic [63:0] dur);
    bus.req = mask; bus.half_period = hp; bus.duration = dur;
    @(negedge clk);
    bus.req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i]) begin
        m_pend[i] = 1'b1;
        m_hp[i]   = int'(hp[16*i +: 16]);
        m_dur[i]  = int'(dur[16*i +: 16]);
      end
    end
    try_grant();
  endtask

  task automatic issue_one(input int idx, input int hp, input int dur);
    logic [63:0] hpv, durv;
    hpv = '0; durv = '0;
    hpv[16*idx +: 16]  = 16'(hp);
    durv[16*idx +: 16] = 16'(dur);
    issue_req(4'(1 << idx), hpv, durv);
  endtask

  // Monitor: after each frame edge, gather done pulses and compare against the queue head.
  initial begin
    exp_t e;
    logic [3:0] done_acc;
    forever begin
      @(posedge lrck);
      done_acc = '0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        done_acc |= bus.done;
      end
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("left",  {16'h0, bus.dacdata_left},  {16'h0, e.sample});
        chk("right", {16'h0, bus.dacdata_right}, {16'h0, e.sample});
        chk("done",  {28'h0, done_acc},          {28'h0, e.done});
        chk("busy",  {31'h0, bus.busy},          {31'h0, e.busy});
        chk("gid",   {30'h0, bus.grant_id},      {30'h0, e.gid});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_left"},  {16'h0, bus.dacdata_left},  32'h0);
    chk({tag, "_right"}, {16'h0, bus.dacdata_right}, 32'h0);
    chk({tag, "_busy"},  {31'h0, bus.busy},          32'h0);
    chk({tag, "_done"},  {28'h0, bus.done},          32'h0);
    chk({tag, "_gid"},   {30'h0, bus.grant_id},      32'h0);
  endtask

  initial begin
    logic [3:0]  mask;
    logic [63:0] hpv, durv;
    bit          mt;

    rst_n = 1'b0; lrck = 1'b0;
    bus.req = '0; bus.half_period = '0; bus.duration = '0; bus.mute = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic tone: +A +A -A -A +A +A then 0 with done[2].
    issue_one(2, 2, 6);
    repeat (8) do_tick(1'b0);

    // Same-cycle requests: 1 before 3.
    hpv = '0; durv = '0;
    hpv[16 +: 16] = 16'd1; durv[16 +: 16] = 16'd3;
    hpv[48 +: 16] = 16'd3; durv[48 +: 16] = 16'd2;
    issue_req(4'b1010, hpv, durv);
    repeat (9) do_tick(1'b0);

    // Preemption of a long tone by source 0 after 10 ticks.
    issue_one(3, 5, 100);
    repeat (10) do_tick(1'b0);
    issue_one(0, 2, 4);
    repeat (8) do_tick(1'b0);

    // Zero duration, then zero half period.
    issue_one(1, 3, 0);
    repeat (2) do_tick(1'b0);
    issue_one(2, 0, 4);
    repeat (6) do_tick(1'b0);

    // Mute on ticks 2-3 of a half-period-1 tone.
    issue_one(0, 1, 4);
    do_tick(1'b0); do_tick(1'b1); do_tick(1'b1);
    repeat (3) do_tick(1'b0);

    // Reset in the middle of a tone, with another source still pending.
    issue_one(2, 3, 20);
    repeat (2) do_tick(1'b0);
    issue_one(3, 2, 5);
    do_tick(1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) do_tick(1'b0);

    // Randomized traffic; the currently playing source is never re-requested.
    for (int t = 0; t < 160; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        mask = 4'($urandom_range(1, 15));
        if (m_play) mask[m_gid] = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
          hpv[16*i +: 16]  = 16'($urandom_range(0, 4));
          durv[16*i +: 16] = 16'($urandom_range(0, 10));
        end
        if (mask != 4'b0) issue_req(mask, hpv, durv);
      end
      mt = ($urandom_range(0, 7) == 0);
      do_tick(mt);
    end

    chk("sb_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sfx_arbiter.md
# audio_sfx_arbiter

Fixed-priority sound-effect scheduler that shares the codec DAC path between game requesters. It latches tone requests (half-period, duration) from up to NUM_REQ sources and plays one at a time as a square wave. Samples advance once per DAC frame, taken from the codec's AUD_DACLRCK. Its outputs drive dacdata_left/dacdata_right of audio_codec_controller.

## Interface
- NUM_REQ, 4: number of requesters; index 0 is highest priority.
- AMPLITUDE, 16'sh2000: positive tone level; the negative level is -AMPLITUDE (two's complement).
- CLOCK31_5 in 1: system clock; same clock as the codec controller.
- resetN in 1: asynchronous, active-low reset.
- AUD_DACLRCK in 1: codec DAC frame clock; asynchronous to CLOCK31_5.
- req in NUM_REQ: level request per source; sampled every cycle.
- half_period in NUM_REQ*16: per-source half period in sample ticks; slice i is [16i+15:16i].
- duration in NUM_REQ*16: per-source length in sample ticks.
- mute in 1: forces output samples to 0; sequencing continues.
- busy out 1: high while in PLAY.
- grant_id out $clog2(NUM_REQ): index of the source being played; holds its last value in IDLE.
- done out NUM_REQ: one-cycle pulse when a source's tone completes naturally.
- dacdata_left out 16: signed sample.
- dacdata_right out 16: signed sample, always equal to left.

## Operation
- Tick generation:
  - AUD_DACLRCK passes through a 2-FF synchronizer, then a rising-edge detect.
  - This produces sample_tick, a one-cycle pulse.
- Request capture:
  - Any cycle with req[i]=1 sets pending[i].
  - The same cycle copies half_period[i] and duration[i] into per-source registers hp_r[i] and dur_r[i].
  - A repeat request before grant overwrites the captured values.
- States: IDLE and PLAY.
- IDLE:
  - If pending≠0, take the lowest set index g: grant_id←g, clear pending[g], load rem←dur_r[g], phase←0, pol←1, go to PLAY next cycle.
  - Samples are 0.
- PLAY: acts only on sample_tick, in the order below.
  - Preempt: if pending holds an index below grant_id, switch to the lowest such index j. Load rem/phase/pol as at grant and clear pending[j]. No done pulse for the old source; its request is discarded. Processing of this tick continues with j.
  - Finish: if rem=0, sample←0, pulse done[grant_id], go to IDLE.
  - Play: otherwise sample←(hp_r=0 ? 0 : pol ? +AMPLITUDE : −AMPLITUDE) and rem←rem−1. If hp_r≠0: when phase=hp_r−1, phase←0 and pol toggles; else phase←phase+1.
- Same-or-lower-priority requests arriving during PLAY wait in pending until IDLE.
- req[i] asserted in the same cycle pending[i] is cleared by a grant: the set wins, so the source is queued again with the new values.
- mute=1 puts 0 on the outputs without changing rem, phase, pol or done timing.
- rem and phase are 16-bit unsigned; rem never wraps below 0.

## Timing
- Reset values:
  - Outputs: dacdata_left/right=0, busy=0, grant_id=0, done=0.
  - Internal: state=IDLE; pending, hp_r, dur_r, rem, phase = 0; pol=1.
- Reset mid-play aborts immediately; no done pulse.
- sample_tick rises 3 CLOCK31_5 cycles after an AUD_DACLRCK rising edge at the pin.
- Grant from IDLE: pending set at cycle N → busy=1 and grant_id valid at N+1.
- The first tone sample appears on the first sample_tick after entering PLAY.
- Preemption takes effect on the tick itself; the new source's first sample is output on that tick.
- Sample registers update only in a sample_tick cycle or on IDLE entry; they are stable between ticks.
- A source with duration D outputs exactly D tone samples. On tick D+1: outputs 0, done pulses, busy falls the following cycle.
- Duration 0: the first tick outputs 0 and pulses done.
- Minimum spacing between two tones: one IDLE cycle.

## Test plan
- Basic tone: req[2] with half_period=2, duration=6. Required samples +0x2000, +0x2000, −0x2000 (0xE000), −0x2000, +0x2000, +0x2000, then 0. done[2] pulses on tick 7.
- Priority: req[3] and req[1] asserted in the same cycle. grant_id=1 plays first; grant_id=3 follows after done[1] plus one IDLE cycle.
- Preemption: source 3 playing (duration=100); req[0] after 10 ticks. Switch occurs on tick 11, done[3] never pulses, source 0 completes with done[0].
- Edge cases:
  - duration=0 → one zero sample plus done, no tone samples.
  - half_period=0, duration=4 → four zero samples, then done.
- mute: tone half_period=1, duration=4 with mute=1 on ticks 2–3. Outputs +A, 0, 0, −A; done timing unchanged.
- Reset mid-play: resetN low during tick 3 of a tone. All outputs 0 immediately, pending cleared, no done; after release, no playback occurs without a new req.
